hbridge_arbiter: RTL and testbench

HBRIDGE_ARBITER -- requirements
Module: hbridge_arbiter

---
 rtl/hb_pkg.sv | 35 +++
 rtl/hb_down_counter.sv | 28 ++
 rtl/hbridge_arbiter.sv | 171 +++++++++++++++++
 tb/tb_hbridge_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hb_pkg.sv
// Shared definitions for the H-bridge arbiter: state encoding, requester
// indices and the layout of a motor command word.
package hb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DEADTIME   = 2'd1,
    ST_DRIVE      = 2'd2,
    ST_STALL_LOCK = 2'd3
  } hb_state_e;

  localparam int NUM_REQ = 3;
  localparam int AVOID   = 2;
  localparam int CORNER  = 1;
  localparam int SEARCH  = 0;

  // cmd word = {en_l, dir_l, en_r, dir_r}
  localparam int CMD_EN_L  = 3;
  localparam int CMD_DIR_L = 2;
  localparam int CMD_EN_R  = 1;
  localparam int CMD_DIR_R = 0;

  localparam int DT_W    = 16;
  localparam int STALL_W = 20;

  // Bridge outputs are ordered {left, right}.
  function automatic logic [1:0] cmd_en(input logic [3:0] c);
    return {c[CMD_EN_L], c[CMD_EN_R]};
  endfunction

  function automatic logic [1:0] cmd_dir(input logic [3:0] c);
    return {c[CMD_DIR_L], c[CMD_DIR_R]};
  endfunction

endpackage

// File: rtl/hb_down_counter.sv
// Loadable down counter that parks at zero; zero_o flags the parked value.
module hb_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hbridge_arbiter.sv
// Fixed-priority owner arbitration for a shared H-bridge with break-before-make
// deadtime on every owner change or live direction reversal, plus stall lockout.
module hbridge_arbiter
  import hb_pkg::*;
#(
  parameter int unsigned DEADTIME_CYC = 1000,
  parameter int unsigned STALL_CYC    = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [3:0]         cmd_avoid,
  input  logic [3:0]         cmd_corner,
  input  logic [3:0]         cmd_search,
  input  logic [1:0]         Sense,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         hb_en,
  output logic [1:0]         hb_dir,
  output logic               stalled
);

  localparam logic [DT_W-1:0]    DT_LOAD   = DT_W'(DEADTIME_CYC - 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_CYC);

  hb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         en_q, en_d, dir_q, dir_d;
  logic               stalled_q, stalled_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               init_q;
  logic               dt_load, dt_dec, dt_zero;

  logic [NUM_REQ-1:0] win;
  logic [3:0]         win_cmd;
  logic [1:0]         win_en, win_dir;
  logic               sensed, stall_hit, live_rev;

  always_comb begin
    win     = '0;
    win_cmd = '0;
    if (req[AVOID]) begin
      win[AVOID] = 1'b1;
      win_cmd    = cmd_avoid;
    end else if (req[CORNER]) begin
      win[CORNER] = 1'b1;
      win_cmd     = cmd_corner;
    end else if (req[SEARCH]) begin
      win[SEARCH] = 1'b1;
      win_cmd     = cmd_search;
    end
  end

  assign win_en  = cmd_en(win_cmd);
  assign win_dir = cmd_dir(win_cmd);

  // Only a direction flip on a motor currently being driven needs deadtime.
  assign live_rev  = |((win_dir ^ dir_q) & en_q);
  assign sensed    = |(Sense & en_q);
  assign stall_hit = (state_q == ST_DRIVE) && (stall_q >= STALL_LIM);

  always_comb begin
    stall_d = '0;
    if (state_q == ST_DRIVE && sensed)
      stall_d = (stall_q >= STALL_LIM) ? stall_q : stall_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    en_d      = en_q;
    dir_d     = dir_q;
    stalled_d = 1'b0;
    dt_load   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // init_q holds off arbitration for the first edge after reset release.
        if (init_q && win != '0) begin
          state_d = ST_DEADTIME;
          grant_d = win;
          dir_d   = win_dir;
          en_d    = '0;
          dt_load = 1'b1;
        end
      end
      ST_DEADTIME: begin
        en_d = '0;
        if (win == '0) begin
          state_d = ST_IDLE;
          grant_d = '0;
          dir_d   = '0;
        end else if (win != grant_q) begin
          grant_d = win;
          dir_d   = win_dir;
          dt_load = 1'b1;
        end else begin
          dir_d = win_dir;
          if (dt_zero) begin
            state_d = ST_DRIVE;
            en_d    = win_en;
          end
        end
      end
      ST_DRIVE: begin
        if (stall_hit) begin
          state_d   = ST_STALL_LOCK;
          grant_d   = '0;
          en_d      = '0;
          stalled_d = 1'b1;
        end else if (win == '0) begin
          state_d = ST_IDLE;
          grant_d = '0;
          en_d    = '0;
          dir_d   = '0;
        end else if (win != grant_q || live_rev) begin
          state_d = ST_DEADTIME;
          grant_d = win;
          dir_d   = win_dir;
          en_d    = '0;
          dt_load = 1'b1;
        end else begin
          en_d  = win_en;
          dir_d = win_dir;
        end
      end
      ST_STALL_LOCK: begin
        grant_d = '0;
        en_d    = '0;
        if (req == '0) state_d   = ST_IDLE;
        else           stalled_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dt_dec = (state_q == ST_DEADTIME);

  hb_down_counter #(.W(DT_W)) u_deadtime (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (dt_load),
    .load_val_i (DT_LOAD),
    .dec_i      (dt_dec),
    .zero_o     (dt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      en_q      <= '0;
      dir_q     <= '0;
      stalled_q <= 1'b0;
      stall_q   <= '0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      stalled_q <= stalled_d;
      stall_q   <= stall_d;
      init_q    <= 1'b1;
    end
  end

  assign grant   = grant_q;
  assign hb_en   = en_q;
  assign hb_dir  = dir_q;
  assign stalled = stalled_q;

endmodule

// File: tb/tb_hbridge_arbiter.sv
// Bench for hbridge_arbiter with DEADTIME_CYC=4, STALL_CYC=8: cycle table plus
// hand sequences for stall, lock release and asynchronous reset.
module tb_hbridge_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [3:0] cmd_avoid, cmd_corner, cmd_search;
  logic [1:0] Sense;
  logic [2:0] grant;
  logic [1:0] hb_en, hb_dir;
  logic       stalled;

  hbridge_arbiter #(.DEADTIME_CYC(4), .STALL_CYC(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .cmd_avoid  (cmd_avoid),
    .cmd_corner (cmd_corner),
    .cmd_search (cmd_search),
    .Sense      (Sense),
    .grant      (grant),
    .hb_en      (hb_en),
    .hb_dir     (hb_dir),
    .stalled    (stalled)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [3:0] ca, cc, cs;
    logic [1:0] sense;
    logic [2:0] g;
    logic [1:0] en, dir;
    logic       st;
  } vec_t;

  localparam logic [3:0] A = 4'b1010;
  localparam logic [3:0] F = 4'b1111;

  vec_t  tbl[$];
  vec_t  exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    failures = 0;

  function automatic vec_t mk(input logic [2:0] rq, input logic [3:0] ca, input logic [3:0] cc,
                              input logic [3:0] cs, input logic [1:0] sn, input logic [2:0] g,
                              input logic [1:0] en, input logic [1:0] dir, input logic st);
    vec_t v;
    v.req = rq; v.ca = ca; v.cc = cc; v.cs = cs; v.sense = sn;
    v.g = g; v.en = en; v.dir = dir; v.st = st;
    return v;
  endfunction

  task automatic add(input vec_t v, input int n);
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk_now(input string nm, input logic [2:0] g, input logic [1:0] en,
                         input logic [1:0] dir, input logic st);
    checks++;
    if (grant !== g || hb_en !== en || hb_dir !== dir || stalled !== st) begin
      failures++;
      $display("FAIL %s: got grant=%b hb_en=%b hb_dir=%b stalled=%b, want %b %b %b %b",
               nm, grant, hb_en, hb_dir, stalled, g, en, dir, st);
    end
  endtask

  task automatic pop_check();
    vec_t  e;
    string n;
    e = exp_q.pop_front();
    n = nm_q.pop_front();
    chk_now(n, e.g, e.en, e.dir, e.st);
  endtask

  // Drive one cycle's inputs, queue what the edge must produce, check after it.
  task automatic cyc(input vec_t v, input string nm);
    @(negedge clk);
    req = v.req; cmd_avoid = v.ca; cmd_corner = v.cc; cmd_search = v.cs; Sense = v.sense;
    exp_q.push_back(v);
    nm_q.push_back(nm);
    @(posedge clk);
    #1 pop_check();
  endtask

  task automatic run(input vec_t v, input int n, input string nm);
    for (int i = 0; i < n; i++) cyc(v, $sformatf("%s[%0d]", nm, i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 3'b000; Sense = 2'b00;
    cmd_avoid = A; cmd_corner = F; cmd_search = F;
    #1 chk_now("reset_t0", 3'b000, 2'b00, 2'b00, 1'b0);
    req = 3'b111; Sense = 2'b11;
    repeat (2) @(posedge clk);
    #1 chk_now("reset_held", 3'b000, 2'b00, 2'b00, 1'b0);
    req = 3'b000; Sense = 2'b00;
    #1 rst_n = 1'b1;

    // Single request, preemption, owner drop, reversal, en-only changes.
    add(mk(3'b000, A, F, F, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0), 1);
    add(mk(3'b001, A, F, F, 2'b00, 3'b001, 2'b00, 2'b11, 1'b0), 4);
    add(mk(3'b001, A, F, F, 2'b00, 3'b001, 2'b11, 2'b11, 1'b0), 2);
    add(mk(3'b101, A, F, F, 2'b00, 3'b100, 2'b00, 2'b00, 1'b0), 4);
    add(mk(3'b101, A, F, F, 2'b00, 3'b100, 2'b11, 2'b00, 1'b0), 1);
    add(mk(3'b001, A, F, F, 2'b00, 3'b001, 2'b00, 2'b11, 1'b0), 1);
    add(mk(3'b000, A, F, F, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0), 1);
    add(mk(3'b010, A, F, F, 2'b00, 3'b010, 2'b00, 2'b11, 1'b0), 4);
    add(mk(3'b010, A, F, F, 2'b00, 3'b010, 2'b11, 2'b11, 1'b0), 1);
    add(mk(3'b010, A, 4'b1011, F, 2'b00, 3'b010, 2'b00, 2'b01, 1'b0), 4);
    add(mk(3'b010, A, 4'b1011, F, 2'b00, 3'b010, 2'b11, 2'b01, 1'b0), 1);
    add(mk(3'b010, A, 4'b0011, F, 2'b00, 3'b010, 2'b01, 2'b01, 1'b0), 1);
    add(mk(3'b010, A, 4'b0111, F, 2'b00, 3'b010, 2'b01, 2'b11, 1'b0), 1);
    add(mk(3'b010, A, 4'b0110, F, 2'b00, 3'b010, 2'b00, 2'b10, 1'b0), 1);
    add(mk(3'b010, A, 4'b0110, F, 2'b11, 3'b010, 2'b00, 2'b10, 1'b0), 3);
    add(mk(3'b010, A, 4'b0110, F, 2'b00, 3'b010, 2'b01, 2'b10, 1'b0), 1);
    add(mk(3'b000, A, F, F, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0), 1);
    foreach (tbl[i]) cyc(tbl[i], $sformatf("vec%0d", i));

    // Stall: 8 sensed cycles, then a preempting request in the detect cycle.
    run(mk(3'b001, A, F, 4'b1000, 2'b00, 3'b001, 2'b00, 2'b00, 1'b0), 4, "stall_dt");
    run(mk(3'b001, A, F, 4'b1000, 2'b00, 3'b001, 2'b10, 2'b00, 1'b0), 1, "stall_drive");
    run(mk(3'b001, A, F, 4'b1000, 2'b10, 3'b001, 2'b10, 2'b00, 1'b0), 8, "stall_count");
    run(mk(3'b101, A, F, 4'b1000, 2'b00, 3'b000, 2'b00, 2'b00, 1'b1), 1, "stall_lock");
    run(mk(3'b101, A, F, 4'b1000, 2'b00, 3'b000, 2'b00, 2'b00, 1'b1), 3, "stall_held");
    run(mk(3'b000, A, F, 4'b1000, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0), 1, "stall_release");

    // Seven sensed cycles, then sense on the disabled motor: never stalls.
    run(mk(3'b001, A, F, 4'b1000, 2'b00, 3'b001, 2'b00, 2'b00, 1'b0), 4, "ns_dt");
    run(mk(3'b001, A, F, 4'b1000, 2'b00, 3'b001, 2'b10, 2'b00, 1'b0), 1, "ns_drive");
    run(mk(3'b001, A, F, 4'b1000, 2'b10, 3'b001, 2'b10, 2'b00, 1'b0), 7, "ns_seven");
    run(mk(3'b001, A, F, 4'b1000, 2'b00, 3'b001, 2'b10, 2'b00, 1'b0), 3, "ns_clear");
    run(mk(3'b001, A, F, 4'b1000, 2'b01, 3'b001, 2'b10, 2'b00, 1'b0), 12, "ns_offmotor");

    // Asynchronous reset between edges while driving.
    run(mk(3'b001, A, F, F, 2'b00, 3'b001, 2'b00, 2'b11, 1'b0), 0, "unused");
    run(mk(3'b000, A, F, F, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0), 1, "rst_pre_idle");
    run(mk(3'b001, A, F, F, 2'b00, 3'b001, 2'b00, 2'b11, 1'b0), 4, "rst_pre_dt");
    run(mk(3'b001, A, F, F, 2'b00, 3'b001, 2'b11, 2'b11, 1'b0), 2, "rst_pre_drive");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_now("rst_async", 3'b000, 2'b00, 2'b00, 1'b0);
    @(posedge clk);
    #1 chk_now("rst_hold", 3'b000, 2'b00, 2'b00, 1'b0);
    #1 rst_n = 1'b1;
    run(mk(3'b001, A, F, F, 2'b00, 3'b000, 2'b00, 2'b00, 1'b0), 1, "rst_first_edge");
    run(mk(3'b001, A, F, F, 2'b00, 3'b001, 2'b00, 2'b11, 1'b0), 4, "rst_after_dt");
    run(mk(3'b001, A, F, F, 2'b00, 3'b001, 2'b11, 2'b11, 1'b0), 1, "rst_after_drive");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
